apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter: TMO, default 15, maximum ACCESS-phase cycles waiting for pready before an error completion (legal 1..255).
REQ-002 pclk  in  1  single clock; all state updates on rising edge.
REQ-003 preset  in  1  reset, synchronous, active-high.
REQ-004 req0  in  1  requester 0 transfer request; held high until ack0.
REQ-005 wr0  in  1  requester 0 direction; 1 = write, 0 = read.
REQ-006 addr0  in  8  requester 0 address.
REQ-007 wdata0  in  8  requester 0 write data.
REQ-008 req1, wr1, addr1, wdata1  in  1/1/8/8  requester 1, same meaning as requester 0.
REQ-009 ack0, ack1  out  1  one-cycle completion pulse to the granted requester.
REQ-010 err  out  1  valid with ackN; 1 = transfer ended by timeout.
REQ-011 rdata  out  8  read data; valid with ackN for read transfers.
REQ-012 psel, pena, pwrite  out  1  APB select, enable and direction to the slave.
REQ-013 paddr, pwr_data  out  8  APB address and write data to the slave.
REQ-014 pready  in  1  slave ready.
REQ-015 pdata  in  8  slave read data.

Function
REQ-016 All outputs shall be registered; no combinational path from any input to any output.
REQ-017 FSM states shall be IDLE, SETUP and ACCESS.
REQ-018 IDLE: if req0 or req1 is high, the arbiter shall grant one requester, latch its wrN/addrN/wdataN into pwrite/paddr/pwr_data and enter SETUP; otherwise it stays in IDLE.
REQ-019 Arbitration: a single active request wins; with both active, the requester not granted last wins; last-grant pointer resets to 1, so requester 0 wins the first contention.
REQ-020 SETUP: psel=1, pena=0 for exactly one cycle, then ACCESS.
REQ-021 ACCESS: psel=1, pena=1; paddr/pwrite/pwr_data stable from SETUP through the end of ACCESS.
REQ-022 pready=1 sampled in ACCESS: next cycle ackN=1 for the granted requester, err=0, rdata=pdata (reads only; rdata unchanged on writes), psel=pena=0, state IDLE.
REQ-023 Timeout: an 8-bit counter cleared on SETUP entry and incremented on each ACCESS cycle with pready=0; ACCESS cycle TMO with pready=0 ends the transfer as in REQ-022 but with err=1 and rdata unchanged.
REQ-024 pready and the timeout limit reached in the same cycle: pready wins, err=0.
REQ-025 Best-case transfer: request sampled in cycle 0, SETUP cycle 1, ACCESS cycle 2, ack in cycle 3; the arbiter returns to IDLE with the ack and samples requests again in that cycle, so a new SETUP starts no earlier than the cycle after the ack.
REQ-026 A requester dropping reqN mid-transfer shall not abort the transfer; ackN is still issued.
REQ-027 ack0 and ack1 shall never be high together; at most one ack per granted transfer.
REQ-028 Requests arriving during SETUP/ACCESS shall be held off, with no effect on the current transfer.
REQ-029 pready outside ACCESS shall be ignored.

Reset
REQ-030 preset high at a clock edge: state=IDLE, psel=pena=pwrite=0, paddr=pwr_data=rdata=0, ack0=ack1=err=0, timeout counter=0, last-grant pointer=1.
REQ-031 Reset mid-transfer shall abandon the transfer with no ack issued; psel and pena are low in the first cycle after reset.

Verification
REQ-032 Single write: req0=1, wr0=1, addr0=0x12, wdata0=0xA5, pready tied 1 -> psel rises next cycle, pena one cycle later, paddr=0x12, pwr_data=0xA5, ack0 pulses 3 cycles after the request, err=0.
REQ-033 Single read with wait states: req1=1, wr1=0, addr1=0x40, pready low for 3 ACCESS cycles, then high with pdata=0x5C -> ACCESS lasts 4 cycles, ack1 pulse with rdata=0x5C, err=0.
REQ-034 Contention: req0=req1=1 held continuously for 4 transfers -> grant order 0,1,0,1, never two acks in one cycle.
REQ-035 Timeout: TMO=4, pready held 0 -> exactly 4 ACCESS cycles, then ack0 with err=1, rdata unchanged, psel=0.
REQ-036 Reset mid-transfer: preset asserted for 1 cycle during ACCESS -> no ack issued, all outputs at reset values, next contention granted to requester 0.
REQ-037 Request withdrawal: req0 dropped during SETUP -> transfer completes, ack0 pulses once, arbiter returns to IDLE.

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
// Bundle of the two requester ports and the APB master port of the arbiter.
// The master modport is the arbiter's view. The slave modport is the view of the requesters and the APB slave.
interface apb_req_arbiter_if;
   logic       req0;
   logic       wr0;
   logic [7:0] addr0;
   logic [7:0] wdata0;
   logic       req1;
   logic       wr1;
   logic [7:0] addr1;
   logic [7:0] wdata1;
   logic       ack0;
   logic       ack1;
   logic       err;
   logic [7:0] rdata;
   logic       psel;
   logic       pena;
   logic       pwrite;
   logic [7:0] paddr;
   logic [7:0] pwr_data;
   logic       pready;
   logic [7:0] pdata;

   modport master (
      input  req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1, pready, pdata,
      output ack0, ack1, err, rdata, psel, pena, pwrite, paddr, pwr_data
   );

   modport slave (
      output req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1, pready, pdata,
      input  ack0, ack1, err, rdata, psel, pena, pwrite, paddr, pwr_data
   );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter that issues one APB transfer at a time.
// A transfer completes on pready, or with an error after TMO wait cycles in ACCESS.
module apb_req_arbiter #(
   parameter int TMO = 15
) (
   input  logic               pclk,
   input  logic               preset,
   apb_req_arbiter_if.master  bus,
   output logic [1:0]         o_state
);
   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

   state_t     r_state;
   logic       r_gnt;
   logic       r_last;
   logic [7:0] r_cnt;
   logic       r_psel;
   logic       r_pena;
   logic       r_pwrite;
   logic [7:0] r_paddr;
   logic [7:0] r_pwr_data;
   logic [7:0] r_rdata;
   logic       r_ack0;
   logic       r_ack1;
   logic       r_err;

   logic       w_pick;
   logic       w_tmo;

   // Under contention, the requester that did not win last time goes first.
   always_comb begin
      w_pick = bus.req1;
      if (bus.req0 && bus.req1) w_pick = ~r_last;
   end

   // r_cnt holds the number of earlier ACCESS cycles without pready.
   assign w_tmo = (r_cnt == 8'(TMO - 1));

   always_ff @(posedge pclk) begin
      if (preset) begin
         r_state    <= IDLE;
         r_gnt      <= 1'b0;
         r_last     <= 1'b1;
         r_cnt      <= 8'd0;
         r_psel     <= 1'b0;
         r_pena     <= 1'b0;
         r_pwrite   <= 1'b0;
         r_paddr    <= 8'd0;
         r_pwr_data <= 8'd0;
         r_rdata    <= 8'd0;
         r_ack0     <= 1'b0;
         r_ack1     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  r_gnt      <= w_pick;
                  r_last     <= w_pick;
                  r_pwrite   <= w_pick ? bus.wr1    : bus.wr0;
                  r_paddr    <= w_pick ? bus.addr1  : bus.addr0;
                  r_pwr_data <= w_pick ? bus.wdata1 : bus.wdata0;
                  r_cnt      <= 8'd0;
                  r_psel     <= 1'b1;
                  r_state    <= SETUP;
               end
            end
            SETUP: begin
               r_pena  <= 1'b1;
               r_state <= ACCESS;
            end
            ACCESS: begin
               // pready takes priority over a timeout that falls in the same cycle.
               if (bus.pready || w_tmo) begin
                  r_ack0  <= ~r_gnt;
                  r_ack1  <= r_gnt;
                  r_err   <= ~bus.pready;
                  r_psel  <= 1'b0;
                  r_pena  <= 1'b0;
                  r_state <= IDLE;
                  if (bus.pready && !r_pwrite) r_rdata <= bus.pdata;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.ack0     = r_ack0;
   assign bus.ack1     = r_ack1;
   assign bus.err      = r_err;
   assign bus.rdata    = r_rdata;
   assign bus.psel     = r_psel;
   assign bus.pena     = r_pena;
   assign bus.pwrite   = r_pwrite;
   assign bus.paddr    = r_paddr;
   assign bus.pwr_data = r_pwr_data;
   assign o_state      = r_state;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with TMO=4: write, waited read, contention, timeout, reset, withdrawal.
module tb_apb_req_arbiter;
   logic       pclk;
   logic       preset;
   logic [1:0] o_state;
   int         n_assert;
   int         n_fail;
   logic [0:0] exp_q[$];
   logic [0:0] exp_gnt;

   apb_req_arbiter_if bus ();

   apb_req_arbiter #(.TMO(4)) dut (
      .pclk    (pclk),
      .preset  (preset),
      .bus     (bus.master),
      .o_state (o_state)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      preset = 1'b1;
      bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.addr0 = 8'h00; bus.wdata0 = 8'h00;
      bus.req1 = 1'b0; bus.wr1 = 1'b0; bus.addr1 = 8'h00; bus.wdata1 = 8'h00;
      bus.pready = 1'b0; bus.pdata = 8'h00;

      // Reset values
      step();
      step();
      chk1("rst_psel", bus.psel, 1'b0);
      chk1("rst_pena", bus.pena, 1'b0);
      chk1("rst_pwrite", bus.pwrite, 1'b0);
      chk8("rst_paddr", bus.paddr, 8'h00);
      chk8("rst_pwr_data", bus.pwr_data, 8'h00);
      chk8("rst_rdata", bus.rdata, 8'h00);
      chk8("rst_acks_err", {5'd0, bus.ack0, bus.ack1, bus.err}, 8'h00);
      chk8("rst_state", {6'd0, o_state}, 8'h00);
      preset = 1'b0;

      // pready while idle must not start or finish anything
      bus.pready = 1'b1;
      step();
      chk8("idle_pready", {5'd0, bus.ack0, bus.ack1, bus.psel}, 8'h00);

      // Single write from requester 0
      bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 8'h12; bus.wdata0 = 8'hA5;
      step();
      chk1("wr_setup_psel", bus.psel, 1'b1);
      chk1("wr_setup_pena", bus.pena, 1'b0);
      chk1("wr_setup_pwrite", bus.pwrite, 1'b1);
      chk8("wr_setup_paddr", bus.paddr, 8'h12);
      chk8("wr_setup_pwr_data", bus.pwr_data, 8'hA5);
      chk8("wr_setup_state", {6'd0, o_state}, 8'h01);
      step();
      chk1("wr_access_psel", bus.psel, 1'b1);
      chk1("wr_access_pena", bus.pena, 1'b1);
      chk8("wr_access_paddr", bus.paddr, 8'h12);
      chk8("wr_access_pwr_data", bus.pwr_data, 8'hA5);
      chk1("wr_no_early_ack", bus.ack0, 1'b0);
      step();
      chk1("wr_ack0", bus.ack0, 1'b1);
      chk1("wr_ack1", bus.ack1, 1'b0);
      chk1("wr_err", bus.err, 1'b0);
      chk8("wr_done_psel_pena", {6'd0, bus.psel, bus.pena}, 8'h00);
      chk8("wr_rdata_kept", bus.rdata, 8'h00);
      bus.req0 = 1'b0;
      step();
      chk1("wr_ack0_pulse", bus.ack0, 1'b0);
      chk1("wr_idle_psel", bus.psel, 1'b0);

      // Read from requester 1 with three wait states
      bus.pready = 1'b0;
      bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 8'h40; bus.wdata1 = 8'hEE;
      step();
      chk1("rd_setup_psel", bus.psel, 1'b1);
      chk1("rd_setup_pwrite", bus.pwrite, 1'b0);
      chk8("rd_setup_paddr", bus.paddr, 8'h40);
      step();
      chk1("rd_access_pena", bus.pena, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk8("rd_wait_sel_ena", {6'd0, bus.psel, bus.pena}, 8'h03);
         chk1("rd_wait_no_ack", bus.ack1, 1'b0);
         chk8("rd_wait_paddr", bus.paddr, 8'h40);
      end
      // This pready lands on the timeout cycle: pready must win
      bus.pready = 1'b1; bus.pdata = 8'h5C;
      step();
      chk1("rd_ack1", bus.ack1, 1'b1);
      chk1("rd_ack0", bus.ack0, 1'b0);
      chk1("rd_err", bus.err, 1'b0);
      chk8("rd_rdata", bus.rdata, 8'h5C);
      chk1("rd_done_psel", bus.psel, 1'b0);
      bus.req1 = 1'b0;
      bus.pdata = 8'h00;
      step();
      chk1("rd_ack1_pulse", bus.ack1, 1'b0);

      // Contention: both held for four transfers, grant order 0,1,0,1
      bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 8'h20; bus.wdata0 = 8'h01;
      bus.req1 = 1'b1; bus.wr1 = 1'b1; bus.addr1 = 8'h30; bus.wdata1 = 8'h02;
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         step();
         chk1("cont_dual_ack", bus.ack0 & bus.ack1, 1'b0);
         if (bus.ack0 || bus.ack1) begin
            exp_gnt = exp_q.pop_front();
            chk1("cont_grant_order", bus.ack1, exp_gnt[0]);
         end
      end
      chk8("cont_all_acked", 8'(exp_q.size()), 8'h00);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      step();
      chk8("cont_idle", {6'd0, bus.psel, bus.ack0 | bus.ack1}, 8'h00);

      // Timeout on a read: four ACCESS cycles then ack0 with err, rdata kept
      bus.pready = 1'b0; bus.pdata = 8'h77;
      bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 8'h55;
      step();
      step();
      chk1("tmo_access_pena", bus.pena, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk1("tmo_wait_pena", bus.pena, 1'b1);
         chk1("tmo_wait_no_ack", bus.ack0, 1'b0);
      end
      step();
      chk1("tmo_ack0", bus.ack0, 1'b1);
      chk1("tmo_err", bus.err, 1'b1);
      chk8("tmo_rdata_kept", bus.rdata, 8'h5C);
      chk1("tmo_psel", bus.psel, 1'b0);
      bus.req0 = 1'b0;
      step();
      chk8("tmo_pulse_end", {6'd0, bus.ack0, bus.err}, 8'h00);

      // Reset during ACCESS of a requester-0 transfer
      bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 8'h99; bus.wdata0 = 8'h3C;
      step();
      step();
      chk1("rstx_in_access", bus.pena, 1'b1);
      preset = 1'b1;
      step();
      chk8("rstx_sel_ena", {6'd0, bus.psel, bus.pena}, 8'h00);
      chk1("rstx_pwrite", bus.pwrite, 1'b0);
      chk8("rstx_paddr", bus.paddr, 8'h00);
      chk8("rstx_pwr_data", bus.pwr_data, 8'h00);
      chk8("rstx_rdata", bus.rdata, 8'h00);
      chk8("rstx_acks_err", {5'd0, bus.ack0, bus.ack1, bus.err}, 8'h00);
      chk8("rstx_state", {6'd0, o_state}, 8'h00);
      preset = 1'b0;
      bus.req0 = 1'b0;
      bus.pready = 1'b1;
      step();
      chk1("rstx_no_ack", bus.ack0, 1'b0);
      bus.req0 = 1'b1; bus.addr0 = 8'h99;
      bus.req1 = 1'b1; bus.addr1 = 8'h66;
      step();
      chk8("rstx_cont_paddr", bus.paddr, 8'h99);
      step();
      step();
      chk1("rstx_cont_ack0", bus.ack0, 1'b1);
      chk1("rstx_cont_ack1", bus.ack1, 1'b0);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      step();

      // Request withdrawn during SETUP still completes once
      bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 8'h0F; bus.wdata0 = 8'hF0;
      step();
      chk1("wd_setup_psel", bus.psel, 1'b1);
      bus.req0 = 1'b0;
      step();
      chk1("wd_access_pena", bus.pena, 1'b1);
      chk8("wd_access_paddr", bus.paddr, 8'h0F);
      step();
      chk1("wd_ack0", bus.ack0, 1'b1);
      chk1("wd_err", bus.err, 1'b0);
      step();
      chk1("wd_ack0_once", bus.ack0, 1'b0);
      chk8("wd_idle_state", {6'd0, o_state}, 8'h00);
      step();
      chk8("wd_stays_idle", {6'd0, bus.psel, bus.ack0}, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
